stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the 17-bit stopwatch/timer datapath. It turns the start/stop and clear buttons, the mode switches and the preset switches into the datapath's control levels: initial-value load enable, count enable, counter mux select, terminal-count select and display-anode reset. It also watches the datapath's terminal-count flag and freezes the count exactly at the limit. It runs entirely in the `clk` domain and sits beside the datapath in the top level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: stable-sample count per button, used only with `STOPWATCH_DEBOUNCE_EN`.
- `MAX_COUNT`, default 9999: full-range limit and clamp value (4-digit display).

Ports:
- `clk`  in  1  system clock; sole clock of the block.
- `reset_n`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `btn_start`  in  1  raw start/stop pushbutton, asynchronous.
- `btn_clear`  in  1  raw clear pushbutton, asynchronous.
- `mode`  in  2  `[1]` direction (0 up, 1 down); `[0]` limit source (0 `sw_val`, 1 `MAX_COUNT`).
- `sw_val`  in  17  preset from switches.
- `tick`  in  1  one-`clk` pulse in the cycle the datapath's ms clock rises.
- `tc_reached`  in  1  datapath terminal-count flag (Time==init or Time==0).
- `init_val`  out  17  value presented to the datapath init register.
- `init_ld_en`  out  1  init register load enable.
- `count_en`  out  1  counter register enable.
- `ctr_select`  out  2  counter mux: 00 init, 01 up, 10 down, 11 zero.
- `tc_select`  out  1  0 compares to init, 1 compares to zero.
- `an_reset`  out  1  active-high display mux reset.
- `running`  out  1  high in RUNNING.
- `done`  out  1  high in DONE.

## Operation
- Button path: 2-FF synchronizer, then rising-edge detect. Each press gives one `start_p` or `clear_p` pulse.
- Mode path: `mode` is passed through a 2-FF synchronizer. `mode_q` is latched on every LOAD entry.
- Effective limit: `lim = mode[0] ? MAX_COUNT : min(sw_val, MAX_COUNT)`.
- `init_val` is registered and written only in the cycle of entry to LOAD. It holds that value at all other times.
  - Up mode: `init_val = lim` (count from 0 up to lim).
  - Down mode: `init_val = lim` (count from lim down to 0).
- Moore outputs are decoded from the state register.
- `tc_select = mode_q[1]` in all states except BOOT.
- States:
  - BOOT (reset state): all enables 0, `ctr_select`=11, `an_reset`=1. Next cycle goes to LOAD.
  - LOAD: `init_ld_en`=1 for exactly one cycle, then PRESET.
  - PRESET: `count_en`=1, `ctr_select` = up ? 11 : 00. Stays until a `tick` is seen, then PAUSED on the next cycle.
  - PAUSED: `count_en`=0. On `start_p`: if `tc_reached`, go to DONE, otherwise go to RUNNING.
  - RUNNING: `ctr_select` = up ? 01 : 10, `count_en = ~tc_reached`.
    - If `tc_reached`, go to DONE.
    - Else on `start_p`, go to PAUSED.
  - DONE: `done`=1, `count_en`=0. `start_p` is ignored.
- Any state except BOOT:
  - `clear_p` goes to LOAD.
  - Synchronized `mode` ≠ `mode_q` also goes to LOAD.
  - `sw_val` changes take effect only via LOAD.
- Priority: `reset_n` low > `clear_p` / mode change > `tc_reached` > `start_p`.

## Timing
- Reset (`reset_n`=0 at a rising edge) gives, next cycle: state BOOT, `init_val`=0, `init_ld_en`=0, `count_en`=0, `ctr_select`=11, `tc_select`=0, `an_reset`=1, `running`=0, `done`=0, synchronizers cleared.
- `an_reset` falls one cycle after `reset_n` deasserts (BOOT→LOAD).
- Button-to-`start_p` latency: 3 `clk` cycles without debounce.
- `init_val` is stable one cycle before and during the `init_ld_en` cycle.
- `count_en` in PRESET and RUNNING is held across whole ms periods; the datapath captures on the ms edge signalled by `tick`.
- `count_en` drops in the same cycle `tc_reached` is high. It is combinational from `tc_reached`; no extra count occurs.
- `start_p` and `tick` in the same cycle in RUNNING: go to PAUSED; that tick's count is already captured.
- Reset mid-RUNNING: the next cycle is BOOT and the count stops.
- `sw_val` greater than `MAX_COUNT` is clamped; a preset of 0 in down mode goes PAUSED, then DONE on start.

## Configuration
- `STOPWATCH_DEBOUNCE_EN` defined: each synchronized button feeds a counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive equal samples.
  - Edge detection runs on the debounced level.
  - Press latency is `DEBOUNCE_CYCLES`+3.
- Not defined: no debounce counters; edge detection runs on the synchronizer output.

## Test plan
- Reset then release, mode=00, sw_val=5: `an_reset` 1→0. LOAD pulse with `init_val`=5. PRESET selects 11 until `tick`, then PAUSED with `count_en`=0.
- From PAUSED, start press, 5 ticks with the datapath model counting up: RUNNING. `count_en` drops the cycle `tc_reached` rises at Time=5; DONE with `done`=1; further starts ignored.
- mode=10, sw_val=3: PRESET selects 00; RUNNING selects 10 with `tc_select`=1; stops at Time=0; DONE.
- mode=01, sw_val=20000: `init_val`=9999. sw_val=12000 with mode=00 also gives 9999.
- RUNNING, clear and start asserted in the same cycle: clear wins, LOAD next cycle, `running`=0.
- With `STOPWATCH_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4: a 3-cycle glitch gives no `start_p`; a 6-cycle press gives exactly one.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Purpose:
//   Sequencing controller for the 17-bit stopwatch/timer datapath. It turns the
//   raw start/stop and clear pushbuttons, the mode switches and the preset
//   switches into the datapath control levels:
//     - initial-value load enable
//     - count enable
//     - counter mux select
//     - terminal-count select
//     - display-anode reset
//   The count is frozen exactly at the limit. When the datapath raises its
//   terminal-count flag, count_en drops in that same cycle, so no extra count
//   is captured.
//
// Configuration:
//   STOPWATCH_DEBOUNCE_EN (macro)
//     When defined, each synchronized button runs through a counter-based
//     debouncer of DEBOUNCE_CYCLES samples before edge detection.
//     When undefined, edge detection runs directly on the synchronizer output.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable-sample count per button (debounce build only)
//   MAX_COUNT        full-range limit and clamp value
//
// Ports:
//   clk         in   system clock, sole clock of the block
//   reset_n     in   synchronous active-low reset
//   btn_start   in   raw start/stop pushbutton (asynchronous)
//   btn_clear   in   raw clear pushbutton (asynchronous)
//   mode[1:0]   in   [1] direction (0 up, 1 down); [0] limit source
//                    (0 sw_val, 1 MAX_COUNT)
//   sw_val      in   preset from switches
//   tick        in   one-cycle pulse in the cycle the datapath ms clock rises
//   tc_reached  in   datapath terminal-count flag
//   init_val    out  value presented to the datapath init register
//   init_ld_en  out  init register load enable
//   count_en    out  counter register enable
//   ctr_select  out  counter mux: 00 init, 01 up, 10 down, 11 zero
//   tc_select   out  0 compares to init, 1 compares to zero
//   an_reset    out  active-high display mux reset
//   running     out  high while counting
//   done        out  high once the limit has been reached
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_COUNT       = 9999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic [1:0]  mode,
  input  logic [16:0] sw_val,
  input  logic        tick,
  input  logic        tc_reached,
  output logic [16:0] init_val,
  output logic        init_ld_en,
  output logic        count_en,
  output logic [1:0]  ctr_select,
  output logic        tc_select,
  output logic        an_reset,
  output logic        running,
  output logic        done
);

  typedef enum logic [2:0] {
    StBoot    = 3'd0,
    StLoad    = 3'd1,
    StPreset  = 3'd2,
    StPaused  = 3'd3,
    StRunning = 3'd4,
    StDone    = 3'd5
  } stateT;

  localparam logic [16:0] MaxVal = 17'(MAX_COUNT);

  // Counter mux encodings
  localparam logic [1:0] SelInit = 2'b00;
  localparam logic [1:0] SelUp   = 2'b01;
  localparam logic [1:0] SelDown = 2'b10;
  localparam logic [1:0] SelZero = 2'b11;

  stateT       stateReg;
  stateT       stateNext;
  logic [16:0] initValReg;
  logic [1:0]  modeSync1Reg;
  logic [1:0]  modeSyncReg;
  logic [1:0]  modeQReg;
  logic [16:0] lim;
  logic        isUp;
  logic        modeChg;
  logic        startP;
  logic        clearP;
  logic [1:0]  btnRaw;
  logic [1:0]  btnPulse;

  // ---------------------------------------------------------------------------
  // Button conditioning
  //   Bit 0 is start, bit 1 is clear. Both buttons get an identical path, so
  //   simultaneous presses produce pulses in the same cycle and the priority
  //   logic in the FSM decides between them.
  // ---------------------------------------------------------------------------
  assign btnRaw = {btn_clear, btn_start};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gBtn
      logic sync1Reg;
      logic sync2Reg;
      logic levelNow;
      logic prevReg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync1Reg <= 1'b0;
          sync2Reg <= 1'b0;
        end else begin
          sync1Reg <= btnRaw[gi];
          sync2Reg <= sync1Reg;
        end
      end

`ifdef STOPWATCH_DEBOUNCE_EN
      // The counter tracks consecutive samples that disagree with the current
      // debounced level. Any agreeing sample restarts the run, so a bounce
      // shorter than DEBOUNCE_CYCLES never reaches the edge detector.
      localparam int CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

      logic [CntW-1:0] cntReg;
      logic            dbReg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cntReg <= '0;
          dbReg  <= 1'b0;
        end else if (sync2Reg == dbReg) begin
          cntReg <= '0;
        end else if (cntReg == CntW'(DEBOUNCE_CYCLES - 1)) begin
          dbReg  <= sync2Reg;
          cntReg <= '0;
        end else begin
          cntReg <= cntReg + 1'b1;
        end
      end

      assign levelNow = dbReg;
`else
      assign levelNow = sync2Reg;
`endif

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          prevReg <= 1'b0;
        end else begin
          prevReg <= levelNow;
        end
      end

      // One pulse per press, on the rising edge of the conditioned level.
      assign btnPulse[gi] = levelNow & ~prevReg;
    end
  endgenerate

  assign startP = btnPulse[0];
  assign clearP = btnPulse[1];

  // ---------------------------------------------------------------------------
  // Mode synchronizer and the mode snapshot taken at every LOAD entry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      modeSync1Reg <= 2'b00;
      modeSyncReg  <= 2'b00;
    end else begin
      modeSync1Reg <= mode;
      modeSyncReg  <= modeSync1Reg;
    end
  end

  // Any switch movement away from the snapshot restarts the sequence, so the
  // datapath never runs with a direction or limit it was not loaded for.
  assign modeChg = (modeSyncReg != modeQReg);
  assign isUp    = ~modeQReg[1];

  // Effective limit. It is evaluated from the synchronized mode so that the
  // value written to init_val matches the snapshot latched at the same edge.
  always_comb begin
    if (modeSyncReg[0]) begin
      lim = MaxVal;
    end else if (sw_val > MaxVal) begin
      lim = MaxVal;
    end else begin
      lim = sw_val;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  //   init_val and the mode snapshot are captured only on the edge that enters
  //   LOAD, so init_val is steady throughout the load-enable cycle and ignores
  //   later switch movement.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stateReg   <= StBoot;
      initValReg <= '0;
      modeQReg   <= 2'b00;
    end else begin
      stateReg <= stateNext;
      if (stateNext == StLoad) begin
        initValReg <= lim;
        modeQReg   <= modeSyncReg;
      end
    end
  end

  assign init_val = initValReg;

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    stateNext  = stateReg;
    init_ld_en = 1'b0;
    count_en   = 1'b0;
    ctr_select = SelZero;
    tc_select  = modeQReg[1];
    an_reset   = 1'b0;
    running    = 1'b0;
    done       = 1'b0;

    case (stateReg)
      StBoot: begin
        tc_select = 1'b0;
        an_reset  = 1'b1;
        stateNext = StLoad;
      end

      StLoad: begin
        init_ld_en = 1'b1;
        stateNext  = StPreset;
      end

      // Preload the counter.
      // In up mode the counter starts from zero and counts toward init.
      // In down mode the counter starts from init and counts toward zero.
      // The datapath captures on the tick edge, so leave PRESET once the tick
      // has been seen.
      StPreset: begin
        count_en   = 1'b1;
        ctr_select = isUp ? SelZero : SelInit;
        if (tick) begin
          stateNext = StPaused;
        end
      end

      // A zero-length run (the preset already equals the terminal value)
      // goes straight to DONE instead of starting.
      StPaused: begin
        if (startP) begin
          stateNext = tc_reached ? StDone : StRunning;
        end
      end

      // count_en is combinational from tc_reached so the datapath cannot
      // capture a step past the limit in the cycle the flag rises.
      StRunning: begin
        running    = 1'b1;
        ctr_select = isUp ? SelUp : SelDown;
        count_en   = ~tc_reached;
        if (tc_reached) begin
          stateNext = StDone;
        end else if (startP) begin
          stateNext = StPaused;
        end
      end

      StDone: begin
        done = 1'b1;
      end

      default: begin
        stateNext = StBoot;
      end
    endcase

    // Clear and mode changes override everything except reset.
    if ((stateReg != StBoot) && (clearP || modeChg)) begin
      stateNext = StLoad;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int MaxCount = 9999;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int HoldCycles   = 9;
  localparam int SettleCycles = 10;
`else
  localparam int HoldCycles   = 4;
  localparam int SettleCycles = 5;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_start;
  logic        btn_clear;
  logic [1:0]  mode;
  logic [16:0] sw_val;
  logic        tick;
  logic        tc_reached;
  logic [16:0] init_val;
  logic        init_ld_en;
  logic        count_en;
  logic [1:0]  ctr_select;
  logic        tc_select;
  logic        an_reset;
  logic        running;
  logic        done;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .MAX_COUNT      (MaxCount)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_start (btn_start),
    .btn_clear (btn_clear),
    .mode      (mode),
    .sw_val    (sw_val),
    .tick      (tick),
    .tc_reached(tc_reached),
    .init_val  (init_val),
    .init_ld_en(init_ld_en),
    .count_en  (count_en),
    .ctr_select(ctr_select),
    .tc_select (tc_select),
    .an_reset  (an_reset),
    .running   (running),
    .done      (done)
  );

  // ---------------------------------------------------------------------------
  // Datapath model: init register, time counter and terminal-count compare
  // ---------------------------------------------------------------------------
  logic [16:0] dpInit = '0;
  logic [16:0] dpTime = '0;

  assign tc_reached = tc_select ? (dpTime == 17'd0) : (dpTime == dpInit);

  always @(posedge clk) begin
    if (init_ld_en) begin
      dpInit <= init_val;
    end
    if (count_en && tick) begin
      case (ctr_select)
        2'b00:   dpTime <= dpInit;
        2'b01:   dpTime <= dpTime + 17'd1;
        2'b10:   dpTime <= dpTime - 17'd1;
        default: dpTime <= 17'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Observers
  // ---------------------------------------------------------------------------
  int          ldCount      = 0;
  logic [16:0] ldVal        = '0;
  int          overrunCount = 0;

  always @(negedge clk) begin
    if (init_ld_en) begin
      ldCount = ldCount + 1;
      ldVal   = init_val;
    end
    if (running && count_en && tc_reached) begin
      overrunCount = overrunCount + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int vecCount = 0;
  int errCount = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
    end
  endtask

  task automatic pressBtn(input bit doStart, input bit doClear);
    btn_start = doStart;
    btn_clear = doClear;
    step(HoldCycles);
    btn_start = 1'b0;
    btn_clear = 1'b0;
    step(SettleCycles);
  endtask

  task automatic giveTick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(2);
  endtask

  // Reference: limit from the mode/preset rules
  function automatic logic [16:0] expLim(input logic [1:0] m, input logic [16:0] s);
    if (m[0]) begin
      return 17'(MaxCount);
    end
    if (s > 17'(MaxCount)) begin
      return 17'(MaxCount);
    end
    return s;
  endfunction

  task automatic checkReset(input string tag);
    checkVal({tag, "_an_reset"}, an_reset, 1);
    checkVal({tag, "_init_val"}, init_val, 0);
    checkVal({tag, "_ld_en"}, init_ld_en, 0);
    checkVal({tag, "_count_en"}, count_en, 0);
    checkVal({tag, "_ctr_sel"}, ctr_select, 3);
    checkVal({tag, "_tc_sel"}, tc_select, 0);
    checkVal({tag, "_running"}, running, 0);
    checkVal({tag, "_done"}, done, 0);
  endtask

  // One complete session: clear/load, preset, run (to the limit if short).
  task automatic runSession(input int idx, input logic [1:0] m, input logic [16:0] s);
    int          ldBefore;
    int          ticks;
    logic [16:0] lim;
    logic [16:0] hold;
    bit          up;

    lim  = expLim(m, s);
    up   = !m[1];
    mode = m;
    sw_val = s;
    step(4);

    ldBefore = ldCount;
    pressBtn(1'b0, 1'b1);
    checkVal("load_seen", 32'(ldCount > ldBefore), 1);
    checkVal("load_val", ldVal, lim);
    checkVal("init_hold", init_val, lim);
    checkVal("preset_en", count_en, 1);
    checkVal("preset_sel", ctr_select, up ? 3 : 0);
    checkVal("tc_sel", tc_select, m[1]);
    checkVal("preset_an", an_reset, 0);

    giveTick();
    checkVal("paused_en", count_en, 0);
    checkVal("paused_run", running, 0);
    checkVal("paused_done", done, 0);
    checkVal("preset_time", dpTime, up ? 0 : lim);

    // Switch movement alone must not disturb the loaded value.
    sw_val = s ^ 17'h00005;
    step(3);
    checkVal("sw_no_effect", init_val, lim);
    sw_val = s;

    ticks = 0;
    pressBtn(1'b1, 1'b0);
    if (lim <= 17'd12) begin
      checkVal("start_run", running, (lim != 0) ? 1 : 0);
      checkVal("start_done", done, (lim == 0) ? 1 : 0);
      if (running) begin
        checkVal("run_sel", ctr_select, up ? 1 : 2);
      end
      while (!done && ticks < int'(lim) + 3) begin
        giveTick();
        ticks++;
      end
      checkVal("done_flag", done, 1);
      checkVal("ticks_to_done", ticks, lim);
      checkVal("final_time", dpTime, up ? lim : 0);
      checkVal("done_en", count_en, 0);
      hold = dpTime;
      pressBtn(1'b1, 1'b0);
      giveTick();
      checkVal("done_sticky", done, 1);
      checkVal("done_frozen", dpTime, hold);
    end else begin
      checkVal("start_run", running, 1);
      for (int k = 0; k < 3; k++) begin
        giveTick();
      end
      pressBtn(1'b1, 1'b0);
      checkVal("pause_run", running, 0);
      giveTick();
      giveTick();
      checkVal("pause_time", dpTime, up ? 3 : lim - 3);
    end
    $display("session %0d mode=%b sw=%0d lim=%0d time=%0d ticks=%0d done=%0b",
             idx, m, s, lim, dpTime, ticks, done);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0]  rm;
    logic [16:0] rs;
    int          ldBefore;
    logic [16:0] hold;

    reset_n   = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    mode      = 2'b00;
    sw_val    = 17'd5;
    tick      = 1'b0;
    step(3);
    checkReset("reset");

    reset_n = 1'b1;
    step(1);
    checkVal("boot_an_fall", an_reset, 0);
    checkVal("boot_ld_en", init_ld_en, 1);
    checkVal("boot_init_val", init_val, 5);
    step(1);
    checkVal("boot_ld_pulse", init_ld_en, 0);
    checkVal("boot_preset_en", count_en, 1);
    checkVal("boot_preset_sel", ctr_select, 3);
    giveTick();
    checkVal("boot_paused_en", count_en, 0);

`ifdef STOPWATCH_DEBOUNCE_EN
    // Short glitch filtered, longer press accepted once.
    btn_start = 1'b1;
    step(3);
    btn_start = 1'b0;
    step(10);
    checkVal("glitch_run", running, 0);
    btn_start = 1'b1;
    step(6);
    btn_start = 1'b0;
    step(10);
    checkVal("press6_run", running, 1);
    pressBtn(1'b1, 1'b0);
    checkVal("press6_pause", running, 0);
`endif

    // Directed sessions
    runSession(0, 2'b00, 17'd5);
    runSession(1, 2'b10, 17'd3);
    runSession(2, 2'b01, 17'd20000);
    runSession(3, 2'b00, 17'd12000);
    runSession(4, 2'b10, 17'd0);
    runSession(5, 2'b00, 17'd0);

    // Randomized sessions
    for (int n = 6; n < 16; n++) begin
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rs = 17'd0;
        3:       rs = 17'($urandom_range(10000, 131071));
        default: rs = 17'($urandom_range(1, 10));
      endcase
      runSession(n, rm, rs);
    end

    // Clear and start together while running: clear wins.
    mode   = 2'b00;
    sw_val = 17'd10;
    step(4);
    pressBtn(1'b0, 1'b1);
    giveTick();
    pressBtn(1'b1, 1'b0);
    giveTick();
    giveTick();
    checkVal("both_pre_run", running, 1);
    ldBefore = ldCount;
    pressBtn(1'b1, 1'b1);
    checkVal("both_load", 32'(ldCount > ldBefore), 1);
    checkVal("both_running", running, 0);
    checkVal("both_preset_en", count_en, 1);
    checkVal("both_init", init_val, 10);
    $display("clear+start: loads=%0d running=%0b", ldCount - ldBefore, running);

    // Reset in the middle of a run stops the count.
    giveTick();
    pressBtn(1'b1, 1'b0);
    giveTick();
    checkVal("midrst_pre_run", running, 1);
    reset_n = 1'b0;
    step(1);
    checkReset("midrst");
    hold = dpTime;
    giveTick();
    checkVal("midrst_frozen", dpTime, hold);
    reset_n = 1'b1;
    step(2);
    checkVal("midrst_release_an", an_reset, 0);
    $display("mid-run reset: time=%0d", dpTime);

    checkVal("no_count_at_tc", overrunCount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
